// File: rtl/multi_currency_accumulator.sv
// ---------------------------------------------------------------------------
// multi_currency_accumulator
//
// Decodes N_DENOM one-hot note switches into denomination values and keeps a
// range-checked running total. Insertions with several switches closed put
// the block into ERROR until every switch opens. A commit or cancel request
// freezes the total into out_amount. The amount is then offered to the
// dispense logic under a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   note_in     raw switch levels, one bit per denomination
//   commit      request payout of the current total
//   cancel      request refund of the current total (wins over commit)
//   out_ready   dispense logic accepts out_amount
//   price       value of the last accepted note
//   total       running total
//   mul_switch  high while in ERROR (more than one switch seen)
//   overflow    one-cycle pulse when a note is rejected for exceeding MAX_TOTAL
//   out_valid   out_amount / out_refund are valid
//   out_amount  amount to dispense or refund
//   out_refund  1 = cancel refund, 0 = committed payout
//   busy        high while a payout is pending; notes are ignored
// ---------------------------------------------------------------------------
module multi_currency_accumulator #(
   parameter int                         N_DENOM      = 6,
   parameter int                         VAL_W        = 7,
   parameter logic [N_DENOM*VAL_W-1:0]   DENOM_VALUES = {7'd100, 7'd50, 7'd20,
                                                         7'd10, 7'd5, 7'd10},
   parameter int                         TOTAL_W      = 12,
   parameter int                         MAX_TOTAL    = 4000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_DENOM-1:0] note_in,
   input  logic               commit,
   input  logic               cancel,
   input  logic               out_ready,
   output logic [VAL_W-1:0]   price,
   output logic [TOTAL_W-1:0] total,
   output logic               mul_switch,
   output logic               overflow,
   output logic               out_valid,
   output logic [TOTAL_W-1:0] out_amount,
   output logic               out_refund,
   output logic               busy
);

   localparam int SUM_W = TOTAL_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_ERROR,
      ST_DISPENSE
   } state_e;

   state_e               state_q, state_d;
   logic [N_DENOM-1:0]   s_cur_q, s_prev_q;
   logic [TOTAL_W-1:0]   total_q, total_d;
   logic [VAL_W-1:0]     price_q, price_d;
   logic                 overflow_q, overflow_d;
   logic [TOTAL_W-1:0]   out_amount_q, out_amount_d;
   logic                 out_refund_q, out_refund_d;

   logic [VAL_W-1:0]     note_value;
   logic                 cur_any;
   logic                 cur_multi;
   logic                 note_event;
   logic [SUM_W-1:0]     sum_ext;
   logic                 sum_fits;

   // -------------------------------------------------------------------------
   // Switch decode
   // -------------------------------------------------------------------------
   // Only used when s_cur_q is one-hot, so OR-ing the selected slices yields
   // exactly the value of the single closed switch.
   always_comb begin
      note_value = '0;
      for (int i = 0; i < N_DENOM; i++) begin
         if (s_cur_q[i]) begin
            note_value = note_value | DENOM_VALUES[i*VAL_W +: VAL_W];
         end
      end
   end

   assign cur_any    = |s_cur_q;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign cur_multi  = |(s_cur_q & (s_cur_q - N_DENOM'(1)));
   // Edge detection: a note counts only when the switches were all open the
   // cycle before, so a held switch or a partial release is never recounted.
   assign note_event = (s_prev_q == '0) && cur_any && !cur_multi;

   // One extra bit keeps the comparison against MAX_TOTAL free of wrap-around.
   assign sum_ext  = SUM_W'(total_q) + SUM_W'(note_value);
   assign sum_fits = (sum_ext <= SUM_W'(MAX_TOTAL));

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every variable driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      total_d      = total_q;
      price_d      = price_q;
      overflow_d   = 1'b0;
      out_amount_d = out_amount_q;
      out_refund_d = out_refund_q;

      unique case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (cur_multi) begin
               // Multi-switch insertion beats commit/cancel; total is kept.
               state_d = ST_ERROR;
            end else begin
               if (note_event) begin
                  if (sum_fits) begin
                     total_d = sum_ext[TOTAL_W-1:0];
                     price_d = note_value;
                     state_d = ST_COLLECT;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               // Commit/cancel only matter with money collected; the payout
               // captures the total including a same-cycle note.
               if ((state_q == ST_COLLECT) && (commit || cancel)) begin
                  state_d      = ST_DISPENSE;
                  out_amount_d = total_d;
                  out_refund_d = cancel;
               end
            end
         end

         ST_ERROR: begin
            if (!cur_any) begin
               state_d = (total_q != '0) ? ST_COLLECT : ST_IDLE;
            end
         end

         ST_DISPENSE: begin
            if (out_ready) begin
               total_d = '0;
               price_d = '0;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments so every register samples the values from
   // before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         s_cur_q      <= '0;
         s_prev_q     <= '0;
         total_q      <= '0;
         price_q      <= '0;
         overflow_q   <= 1'b0;
         out_amount_q <= '0;
         out_refund_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_cur_q      <= note_in;
         s_prev_q     <= s_cur_q;
         total_q      <= total_d;
         price_q      <= price_d;
         overflow_q   <= overflow_d;
         out_amount_q <= out_amount_d;
         out_refund_q <= out_refund_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign price      = price_q;
   assign total      = total_q;
   assign overflow   = overflow_q;
   assign out_amount = out_amount_q;
   assign out_refund = out_refund_q;
   assign mul_switch = (state_q == ST_ERROR);
   assign out_valid  = (state_q == ST_DISPENSE);
   assign busy       = (state_q == ST_DISPENSE);

endmodule

// File: doc/multi_currency_accumulator.md
# multi_currency_accumulator

Parametrised successor to the single-cycle currency decoder. It decodes N one-hot denomination switches into values and accumulates inserted notes into a running total, with range checking. It flags multi-switch insertions and holds the payout amount under a valid/ready handshake until the downstream dispense logic accepts it. It sits between the front-panel note switches and the ATM transaction/dispense controller.

## Interface
- N_DENOM, 6, number of denomination switches
- VAL_W, 7, width of one denomination value
- DENOM_VALUES, {7'd100,7'd50,7'd20,7'd10,7'd5,7'd10}, packed value table; slice i (bits i*VAL_W +: VAL_W) is the value of note_in[i]; default bit0=10, bit1=5, bit2=10, bit3=20, bit4=50, bit5=100
- TOTAL_W, 12, accumulator width
- MAX_TOTAL, 4000, largest legal total; must be below 2^TOTAL_W

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- note_in  in  N_DENOM  switch levels, one bit per denomination
- commit  in  1  request payout of the current total
- cancel  in  1  request refund of the current total
- out_ready  in  1  dispense logic accepts out_amount
- price  out  VAL_W  value of the last accepted note
- total  out  TOTAL_W  running total
- mul_switch  out  1  high while in ERROR (more than one switch seen)
- overflow  out  1  one-cycle pulse: note rejected, would exceed MAX_TOTAL
- out_valid  out  1  out_amount/out_refund valid
- out_amount  out  TOTAL_W  amount to dispense or refund
- out_refund  out  1  1 = cancel refund, 0 = committed payout
- busy  out  1  high in DISPENSE; notes are not accepted

## Operation
- note_in registered into s_cur each cycle; s_prev holds the previous s_cur.
- Note event: s_prev == 0 and s_cur one-hot. The value is DENOM_VALUES slice of the set bit.
- Multi event: s_cur has two or more bits set, in IDLE or COLLECT.
- States: IDLE (total == 0), COLLECT (total > 0), ERROR, DISPENSE.
- IDLE/COLLECT, note event:
  - If total + value <= MAX_TOTAL: total += value, price = value, go to COLLECT.
  - Otherwise: total unchanged, overflow pulses, price unchanged.
  - Sum computed at TOTAL_W+1 bits; there is no wrap-around.
- IDLE/COLLECT, multi event: go to ERROR; total preserved; the note is not counted. A multi event has priority over commit/cancel in the same cycle.
- ERROR: mul_switch=1. Exit when s_cur == 0: go to COLLECT if total > 0, else IDLE. Partial release to a single bit does not count as a note, because s_prev is nonzero.
- COLLECT, cancel (cancel wins over commit): go to DISPENSE with out_refund=1.
- COLLECT, commit: go to DISPENSE with out_refund=0.
- A note event in the same cycle as commit/cancel is still accumulated (or rejected). out_amount captures the post-update total.
- commit/cancel in IDLE (total == 0) are ignored.
- DISPENSE:
  - out_valid=1, busy=1; out_amount/out_refund held stable.
  - Note events are ignored; s_prev still tracks s_cur, so releasing the switch later does not generate an event.
  - When out_valid && out_ready: total=0, price=0, go to IDLE.
- Reset values: state IDLE, s_cur=s_prev=0, total=0, price=0, mul_switch=0, overflow=0, out_valid=0, out_amount=0, out_refund=0, busy=0.
- A reset mid-DISPENSE drops the pending payout without a handshake.

## Timing
- note_in change before edge k is captured in s_cur at k. total/price/overflow update at edge k+1 (2-edge latency from pin).
- mul_switch rises at edge k+1 after a multi pattern is set before edge k. It falls at the edge after s_cur samples all-zero.
- commit/cancel sampled at edge j in COLLECT: out_valid high after edge j.
- Handshake completes at the first edge with out_ready=1. out_valid is low after that edge. out_ready held high makes DISPENSE last exactly one cycle.
- out_ready while out_valid=0 has no effect.
- overflow lasts exactly one cycle per rejected note.

## Test plan
- Reset, then insert bit5 (100), release, insert bit1 (5), release -> total 100 then 105; price 100 then 5; each update two edges after the pin change.
- Hold bit2 for 20 cycles -> counted once (total 10). Set bit2|bit3 -> mul_switch=1, total unchanged. Release to bit3 only, then 0 -> no count, mul_switch clears, state COLLECT.
- Accumulate 3950, insert 100 -> overflow one-cycle pulse, total 3950. Insert 50 -> total 4000.
- total 35, commit with out_ready=0 for 5 cycles -> out_valid, out_amount=35, out_refund=0 held stable and notes ignored. Raise out_ready -> total 0, IDLE.
- total 20, commit+cancel together with a note event of 50 -> out_amount=70, out_refund=1. Commit in IDLE -> no out_valid.
- Assert rst in DISPENSE -> all outputs 0 on the next edge. Override DENOM_VALUES (N_DENOM=8, VAL_W=8, value 200 on bit7) -> total 200.
